lsu_sram: RTL
=============

# lsu_sram

Load/store unit for the MEM stage of the non-cached SRAM-interface MIPS core. It turns one MEM-stage memory operation into a single SRAM-like bus transaction, meaning one request followed by one response. It stalls the pipeline until the response arrives. Its outputs are:
- right-justified, sign- or zero-extended load data, or byte-enabled store data;
- address-error flags for misaligned accesses.

## Interface
Parameters: none.

- clk  in  1  core clock
- resetn  in  1  asynchronous, active-low reset
- mem_en  in  1  MEM stage holds a valid load/store
- mem_wr  in  1  1 = store, 0 = load
- mem_size  in  2  0 = byte, 1 = halfword, 2 = word
- mem_unsigned  in  1  zero-extend load (LBU/LHU)
- mem_addr  in  32  byte address
- mem_wdata  in  32  store data, right-justified
- flush  in  1  exception/eret flush from WB
- data_req  out  1  bus request
- data_wr  out  1  bus write
- data_size  out  2  bus size (same encoding as mem_size)
- data_addr  out  32  bus address
- data_wstrb  out  4  byte enables
- data_wdata  out  32  lane-replicated store data
- data_addr_ok  in  1  request accepted
- data_data_ok  in  1  response valid
- data_rdata  in  32  read data
- ld_data  out  32  extended load result
- done  out  1  one-cycle completion pulse
- stall  out  1  hold pipeline
- adel  out  1  load address error
- ades  out  1  store address error

## Operation
- States: IDLE, REQ, WAIT, DONE. There is also a cancel flag `cnl`.
- Misaligned access: halfword with addr[0]≠0, or word with addr[1:0]≠0.
  - adel/ades are combinational: mem_en & misaligned & ~mem_wr / mem_wr.
  - No bus request is issued; stall = 0.
- Start condition: state IDLE & mem_en & ~misaligned & ~flush. When it holds:
  - latch wr, size, unsigned, addr, wstrb, wdata;
  - go to REQ.
- REQ:
  - data_req = 1 and all bus fields are held stable until data_addr_ok.
  - addr_ok only → WAIT.
  - addr_ok & data_ok in the same cycle → DONE, capturing rdata.
  - data_ok without addr_ok is ignored.
- WAIT: data_ok → DONE, or → IDLE if cnl is set.
- DONE: lasts one cycle, with done = 1. mem_en is ignored (it is the same instruction) → IDLE.
- Flush:
  - In REQ or WAIT, flush sets cnl. The request is not withdrawn.
  - When the response arrives, it is discarded: no done, ld_data unchanged, → IDLE. cnl is cleared on entering IDLE.
  - Flush in DONE has no effect.
- stall:
  - 1 when the start condition holds;
  - 1 in REQ or WAIT with cnl = 0;
  - 1 when cnl = 1 and mem_en = 1 (a new op waits for the cancelled transaction to drain).
  - 0 otherwise.
- Store strobes (o = addr[1:0]):
  - byte: 4'b0001<<o, wdata = {4{wdata[7:0]}};
  - half: 4'b0011<<o, wdata = {2{wdata[15:0]}};
  - word: 4'b1111, wdata passed through.
- Bus fields for loads: data_wstrb = 0; data_addr = full mem_addr.
- Load extraction:
  - byte = rdata[8o+7:8o];
  - half = rdata[16·addr[1]+15 : 16·addr[1]];
  - byte/half are extended with bit 7/15, or with zero if unsigned;
  - word is passed through.
- ld_data is registered on the response edge. Stores also pulse done.

## Timing
- Reset values:
  - state IDLE, cnl 0, ld_data 0, done 0;
  - latched request fields 0, so data_req = data_wr = 0 and data_size/addr/wstrb/wdata = 0;
  - stall 0.
- resetn low mid-transaction: returns to IDLE immediately; the outstanding transaction is abandoned, since the bus shares the same reset.
- Latency, with mem_en at cycle T:
  - data_req rises at T+1;
  - addr_ok at T+1 and data_ok at T+2 → done and ld_data valid at T+3;
  - stall high T..T+2, low at T+3.
- Minimum latency: addr_ok & data_ok at T+1 → done at T+2.
- At most one transaction outstanding; no pipelining of requests.

## Structure
- Shared package holds:
  - size constants SZ_BYTE = 0, SZ_HALF = 1, SZ_WORD = 2;
  - the state enum.
- One sub-module, `lsu_load_align` (combinational): takes rdata, offset, size and unsigned; produces the extended ld_data.
- The FSM, store-lane generation and registers live in the top level.

## Test plan
- LH at address 0x1002, rdata 0x8001_1234, addr_ok at T+1, data_ok at T+3 → done at T+4, ld_data 0xFFFF_8001; stall high T..T+3.
- LBU at address 0x0003, rdata 0xAB00_0000, addr_ok & data_ok at T+1 → done at T+2, ld_data 0x0000_00AB.
- SB at address 0x0001, wdata 0x0000_005A → data_wstrb 4'b0010, data_wdata 0x5A5A_5A5A, data_wr 1; done after data_ok.
- LW at address 0x0006 → adel = 1 the same cycle, data_req never asserted, stall 0. SH at address 0x0003 → ades = 1.
- LW with flush in WAIT:
  - data_req stays correct through addr_ok; data_ok later produces no done and ld_data is unchanged;
  - a new mem_en before that data_ok sees stall = 1;
  - the new op's data_req rises the cycle after the drain.
- resetn asserted low in WAIT → data_req 0, stall 0, ld_data 0; the next LW after release starts cleanly.

Source files
------------

// File: rtl/lsu_sram_pkg.sv
// Shared types and helpers for the SRAM-interface load/store unit.
package lsu_sram_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } lsu_state_e;

  // Request fields latched at start and held on the bus until accepted.
  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } lsu_req_t;

  // Size 3 is undefined on the core side; treat it like a word everywhere.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_BYTE: misaligned = 1'b0;
      SZ_HALF: misaligned = off[0];
      default: misaligned = |off;
    endcase
  endfunction

  function automatic logic [3:0] store_strb(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_BYTE: store_strb = 4'b0001 << off;
      SZ_HALF: store_strb = 4'b0011 << off;
      default: store_strb = 4'b1111;
    endcase
  endfunction

  // Replicate right-justified store data across every lane it may land on.
  function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] wdata);
    case (size)
      SZ_BYTE: store_lanes = {4{wdata[7:0]}};
      SZ_HALF: store_lanes = {2{wdata[15:0]}};
      default: store_lanes = wdata;
    endcase
  endfunction

endpackage

// File: rtl/lsu_sram_load_align.sv
// Right-justifies and extends the addressed byte/halfword of a read word.
module lsu_load_align
  import lsu_sram_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  off_i,
  input  logic [1:0]  size_i,
  input  logic        uns_i,
  output logic [31:0] ld_data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        bsign;
  logic        hsign;

  // Lane select then sign/zero extension by access size.
  always_comb begin
    byte_sel  = rdata_i[{off_i, 3'b000} +: 8];
    half_sel  = rdata_i[{off_i[1], 4'b0000} +: 16];
    bsign     = ~uns_i & byte_sel[7];
    hsign     = ~uns_i & half_sel[15];
    ld_data_o = rdata_i;
    case (size_i)
      SZ_BYTE: ld_data_o = {{24{bsign}}, byte_sel};
      SZ_HALF: ld_data_o = {{16{hsign}}, half_sel};
      default: ld_data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/lsu_sram.sv
// MEM-stage load/store unit: one SRAM-like request/response per operation,
// stalling the pipeline until the response, with flush-cancel draining.
module lsu_sram
  import lsu_sram_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        mem_en,
  input  logic        mem_wr,
  input  logic [1:0]  mem_size,
  input  logic        mem_unsigned,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic        flush,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [3:0]  data_wstrb,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata,
  output logic [31:0] ld_data,
  output logic        done,
  output logic        stall,
  output logic        adel,
  output logic        ades
);

  lsu_state_e  state_q;
  logic        cnl_q;
  lsu_req_t    req_q;
  lsu_req_t    req_d;
  logic [31:0] ld_q;
  logic        done_q;

  logic        misal;
  logic        start;
  logic        cancel;
  logic [31:0] ld_align;

  assign misal  = misaligned(mem_size, mem_addr[1:0]);
  assign adel   = mem_en & misal & ~mem_wr;
  assign ades   = mem_en & misal & mem_wr;
  assign start  = (state_q == ST_IDLE) & mem_en & ~misal & ~flush;
  // A flush arriving on the response cycle itself also discards that response.
  assign cancel = cnl_q | flush;

  // Fields captured when a new operation starts; loads drive no strobes.
  always_comb begin
    req_d       = '0;
    req_d.wr    = mem_wr;
    req_d.size  = mem_size;
    req_d.uns   = mem_unsigned;
    req_d.addr  = mem_addr;
    req_d.wstrb = mem_wr ? store_strb(mem_size, mem_addr[1:0]) : 4'b0000;
    req_d.wdata = store_lanes(mem_size, mem_wdata);
  end

  lsu_load_align u_align (
    .rdata_i   (data_rdata),
    .off_i     (req_q.addr[1:0]),
    .size_i    (req_q.size),
    .uns_i     (req_q.uns),
    .ld_data_o (ld_align)
  );

  // Transaction FSM with cancel flag, latched request and load result.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      cnl_q   <= 1'b0;
      req_q   <= '0;
      ld_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          cnl_q <= 1'b0;
          if (start) begin
            req_q   <= req_d;
            state_q <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (flush) cnl_q <= 1'b1;
          // data_ok before the request is accepted cannot belong to it.
          if (data_addr_ok) begin
            if (!data_data_ok) begin
              state_q <= ST_WAIT;
            end else if (cancel) begin
              state_q <= ST_IDLE;
              cnl_q   <= 1'b0;
            end else begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
              if (!req_q.wr) ld_q <= ld_align;
            end
          end
        end
        ST_WAIT: begin
          if (flush) cnl_q <= 1'b1;
          if (data_data_ok) begin
            if (cancel) begin
              state_q <= ST_IDLE;
              cnl_q   <= 1'b0;
            end else begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
              if (!req_q.wr) ld_q <= ld_align;
            end
          end
        end
        ST_DONE: begin
          // Same instruction still in MEM this cycle; do not restart on it.
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // A cancelled transaction only stalls a new op waiting behind it.
  assign stall = start
               | (((state_q == ST_REQ) | (state_q == ST_WAIT)) & ~cnl_q)
               | (cnl_q & mem_en);

  assign data_req   = (state_q == ST_REQ);
  assign data_wr    = req_q.wr;
  assign data_size  = req_q.size;
  assign data_addr  = req_q.addr;
  assign data_wstrb = req_q.wstrb;
  assign data_wdata = req_q.wdata;
  assign ld_data    = ld_q;
  assign done       = done_q;

endmodule
